// File: rtl/multi_cycle_ctrl_if.sv
// Control bundle between the multi-cycle controller and the shared datapath.
// master = controller side, slave = datapath side.
interface multi_cycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic             zero;
    logic             PCWre;
    logic             IRWre;
    logic             InsMemRW;
    logic             ALUSrcA;
    logic             ALUSrcB;
    logic             ExtSel;
    logic [2:0]       ALUOp;
    logic [1:0]       RegDst;
    logic             RegWre;
    logic             WrRegDSrc;
    logic             DBDataSrc;
    logic             mRD;
    logic             mWR;
    logic [1:0]       PCSrc;
    logic [2:0]       state;
    logic             halted;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  opcode, zero,
        output PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel, ALUOp,
               RegDst, RegWre, WrRegDSrc, DBDataSrc, mRD, mWR, PCSrc,
               state, halted, cycle_cnt, instr_cnt
    );

    modport slave (
        output opcode, zero,
        input  PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel, ALUOp,
               RegDst, RegWre, WrRegDSrc, DBDataSrc, mRD, mWR, PCSrc,
               state, halted, cycle_cnt, instr_cnt
    );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control unit: walks the shared datapath through
// IF/ID/EXE/MEM/WB, decodes the datapath selects from state + opcode and
// keeps cycle / retired-instruction counters for the performance display.
module multi_cycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic                    CLK,
    input  logic                    Reset,
    multi_cycle_ctrl_if.master      bus
);
    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_e;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b010000;
    localparam logic [5:0] OP_ANDI  = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLT   = 6'b100110;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    state_e           state_q, state_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

    // per-opcode datapath decode (used from EXE onward)
    logic       dec_alu, dec_rtype, dec_src_a, dec_src_b, dec_ext;
    logic [2:0] dec_alu_op;

    // combinational control outputs
    logic       pc_wre, ir_wre, ins_mem_rw, alu_src_a, alu_src_b, ext_sel;
    logic [2:0] alu_op;
    logic [1:0] reg_dst, pc_src;
    logic       reg_wre, wr_reg_d_src, db_data_src, m_rd, m_wr;

    // Opcode decode: ALU-class membership, R/I-type and operand selects.
    always_comb begin
        dec_alu    = 1'b0;
        dec_rtype  = 1'b0;
        dec_src_a  = 1'b0;
        dec_src_b  = 1'b0;
        dec_ext    = 1'b0;
        dec_alu_op = 3'b000;
        case (bus.opcode)
            OP_ADD:   begin dec_alu = 1'b1; dec_rtype = 1'b1; end
            OP_SUB:   begin dec_alu = 1'b1; dec_rtype = 1'b1; dec_alu_op = 3'b001; end
            OP_ADDIU: begin dec_alu = 1'b1; dec_src_b = 1'b1; dec_ext = 1'b1; end
            OP_AND:   begin dec_alu = 1'b1; dec_rtype = 1'b1; dec_alu_op = 3'b100; end
            OP_ANDI:  begin dec_alu = 1'b1; dec_src_b = 1'b1; dec_alu_op = 3'b100; end
            OP_ORI:   begin dec_alu = 1'b1; dec_src_b = 1'b1; dec_alu_op = 3'b011; end
            OP_SLL:   begin dec_alu = 1'b1; dec_rtype = 1'b1; dec_src_a = 1'b1; dec_alu_op = 3'b010; end
            OP_SLT:   begin dec_alu = 1'b1; dec_rtype = 1'b1; dec_alu_op = 3'b110; end
            OP_SW, OP_LW:   begin dec_src_b = 1'b1; dec_ext = 1'b1; end
            OP_BEQ, OP_BNE: begin dec_ext = 1'b1; dec_alu_op = 3'b001; end
            default: ;
        endcase
    end

    // Control outputs from state, opcode and zero; all zero while halted.
    always_comb begin
        pc_wre       = 1'b0;
        ir_wre       = 1'b0;
        ins_mem_rw   = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = 1'b0;
        ext_sel      = 1'b0;
        alu_op       = 3'b000;
        reg_dst      = 2'b00;
        pc_src       = 2'b00;
        reg_wre      = 1'b0;
        wr_reg_d_src = 1'b0;
        db_data_src  = 1'b0;
        m_rd         = 1'b0;
        m_wr         = 1'b0;
        if (!halted_q) begin
            // operand selects stay stable from EXE through MEM/WB
            if (state_q != S_IF && state_q != S_ID) begin
                alu_src_a = dec_src_a;
                alu_src_b = dec_src_b;
                ext_sel   = dec_ext;
                alu_op    = dec_alu_op;
            end
            case (state_q)
                S_IF: begin
                    ins_mem_rw = 1'b1;
                    ir_wre     = 1'b1;
                end
                S_ID: begin
                    case (bus.opcode)
                        OP_J:   begin pc_wre = 1'b1; pc_src = 2'b11; end
                        OP_JR:  begin pc_wre = 1'b1; pc_src = 2'b10; end
                        OP_JAL: begin pc_wre = 1'b1; pc_src = 2'b11; reg_wre = 1'b1; end
                        OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_ORI, OP_SLL,
                        OP_SLT, OP_SW, OP_LW, OP_BEQ, OP_BNE, OP_HALT: ;
                        default: pc_wre = 1'b1;   // undefined opcode retires as a NOP
                    endcase
                end
                S_EXE_BR: begin
                    pc_wre = 1'b1;
                    if ((bus.opcode == OP_BEQ && bus.zero) ||
                        (bus.opcode == OP_BNE && !bus.zero))
                        pc_src = 2'b01;
                end
                S_MEM: begin
                    if (bus.opcode == OP_SW) begin
                        m_wr   = 1'b1;
                        pc_wre = 1'b1;
                    end else begin
                        m_rd   = 1'b1;
                    end
                end
                S_WB_AL: begin
                    reg_wre      = 1'b1;
                    wr_reg_d_src = 1'b1;
                    reg_dst      = dec_rtype ? 2'b10 : 2'b01;
                    pc_wre       = 1'b1;
                end
                S_WB_LD: begin
                    reg_wre      = 1'b1;
                    wr_reg_d_src = 1'b1;
                    db_data_src  = 1'b1;
                    reg_dst      = 2'b01;
                    m_rd         = 1'b1;
                    pc_wre       = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next-state, halt flag and counter updates.
    always_comb begin
        state_d     = state_q;
        halted_d    = halted_q;
        cycle_cnt_d = halted_q ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
        instr_cnt_d = pc_wre ? instr_cnt_q + CNT_W'(1) : instr_cnt_q;
        if (!halted_q) begin
            case (state_q)
                S_IF: state_d = S_ID;
                S_ID: begin
                    if (bus.opcode == OP_BEQ || bus.opcode == OP_BNE)
                        state_d = S_EXE_BR;
                    else if (bus.opcode == OP_LW || bus.opcode == OP_SW)
                        state_d = S_EXE_LS;
                    else if (bus.opcode == OP_HALT)
                        halted_d = 1'b1;          // HLT is displayed as ID + halted
                    else if (dec_alu)
                        state_d = S_EXE_AL;
                    else
                        state_d = S_IF;
                end
                S_EXE_AL: state_d = S_WB_AL;
                S_EXE_LS: state_d = S_MEM;
                S_MEM:    state_d = (bus.opcode == OP_LW) ? S_WB_LD : S_IF;
                default:  state_d = S_IF;
            endcase
        end
    end

    // State and counter registers; reset returns to IF with counters cleared.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q     <= S_IF;
            halted_q    <= 1'b0;
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            halted_q    <= halted_d;
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign bus.PCWre     = pc_wre;
    assign bus.IRWre     = ir_wre;
    assign bus.InsMemRW  = ins_mem_rw;
    assign bus.ALUSrcA   = alu_src_a;
    assign bus.ALUSrcB   = alu_src_b;
    assign bus.ExtSel    = ext_sel;
    assign bus.ALUOp     = alu_op;
    assign bus.RegDst    = reg_dst;
    assign bus.RegWre    = reg_wre;
    assign bus.WrRegDSrc = wr_reg_d_src;
    assign bus.DBDataSrc = db_data_src;
    assign bus.mRD       = m_rd;
    assign bus.mWR       = m_wr;
    assign bus.PCSrc     = pc_src;
    assign bus.state     = state_q;
    assign bus.halted    = halted_q;
    assign bus.cycle_cnt = cycle_cnt_q;
    assign bus.instr_cnt = instr_cnt_q;
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: per-cycle vector table for each
// instruction class, plus hand sequences for HLT, async reset and counter wrap.
module tb_multi_cycle_ctrl;
    logic CLK;
    logic Reset;

    multi_cycle_ctrl_if #(.CNT_W(32)) tb_if ();
    multi_cycle_ctrl_if #(.CNT_W(4))  sm_if ();

    multi_cycle_ctrl #(.CNT_W(32)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (tb_if)
    );

    multi_cycle_ctrl #(.CNT_W(4)) dut_small (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (sm_if)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    localparam logic [5:0] OP_ADD = 6'b000000, OP_ADDIU = 6'b000010, OP_ANDI = 6'b010001,
                           OP_ORI = 6'b010010, OP_SLL = 6'b011000, OP_SLT = 6'b100110,
                           OP_SW = 6'b110000, OP_LW = 6'b110001, OP_BEQ = 6'b110100,
                           OP_BNE = 6'b110101, OP_J = 6'b111000, OP_JR = 6'b111001,
                           OP_JAL = 6'b111010, OP_NOP = 6'b101010, OP_HALT = 6'b111111;

    // ctl layout: {PCWre,IRWre,InsMemRW, ALUSrcA,ALUSrcB,ExtSel, ALUOp, RegDst,
    //              RegWre,WrRegDSrc,DBDataSrc, mRD,mWR, PCSrc}
    localparam logic [17:0] C_IF = 18'b011_000_000_00_000_00_00;
    localparam logic [17:0] C_0  = 18'b000_000_000_00_000_00_00;

    typedef struct {
        logic [5:0]  opcode;
        logic        zero;
        logic [2:0]  state;
        logic        halted;
        logic [17:0] ctl;
    } vec_t;

    vec_t tbl[$];
    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] exp_cycle;
    logic [31:0] exp_instr;

    function automatic vec_t mk(input logic [5:0] op, input logic z, input logic [2:0] s,
                                input logic h, input logic [17:0] c);
        vec_t v;
        v.opcode = op; v.zero = z; v.state = s; v.halted = h; v.ctl = c;
        return v;
    endfunction

    function automatic logic [17:0] ctl_now();
        return {tb_if.PCWre, tb_if.IRWre, tb_if.InsMemRW, tb_if.ALUSrcA, tb_if.ALUSrcB,
                tb_if.ExtSel, tb_if.ALUOp, tb_if.RegDst, tb_if.RegWre, tb_if.WrRegDSrc,
                tb_if.DBDataSrc, tb_if.mRD, tb_if.mWR, tb_if.PCSrc};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // drive one cycle's inputs, compare mid-cycle, then advance one clock
    task automatic apply_row(input vec_t v, input string tag);
        tb_if.opcode = v.opcode;
        tb_if.zero   = v.zero;
        #1;
        check({tag, " state"},  64'(tb_if.state),     64'(v.state));
        check({tag, " halted"}, 64'(tb_if.halted),    64'(v.halted));
        check({tag, " ctl"},    64'(ctl_now()),       64'(v.ctl));
        check({tag, " cycle"},  64'(tb_if.cycle_cnt), 64'(exp_cycle));
        check({tag, " instr"},  64'(tb_if.instr_cnt), 64'(exp_instr));
        @(posedge CLK);
        #1;
        if (!v.halted) exp_cycle = exp_cycle + 1;
        if (v.ctl[17]) exp_instr = exp_instr + 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t hv;
        Reset = 1'b0;
        tb_if.opcode = OP_ADD;
        tb_if.zero   = 1'b0;
        sm_if.opcode = OP_NOP;
        sm_if.zero   = 1'b0;
        exp_cycle = 0;
        exp_instr = 0;

        // add
        tbl.push_back(mk(OP_ADD, 0, 3'd0, 0, C_IF));
        tbl.push_back(mk(OP_ADD, 0, 3'd1, 0, C_0));
        tbl.push_back(mk(OP_ADD, 0, 3'd6, 0, C_0));
        tbl.push_back(mk(OP_ADD, 0, 3'd7, 0, 18'b100_000_000_10_110_00_00));
        // lw
        tbl.push_back(mk(OP_LW, 0, 3'd0, 0, C_IF));
        tbl.push_back(mk(OP_LW, 0, 3'd1, 0, C_0));
        tbl.push_back(mk(OP_LW, 0, 3'd2, 0, 18'b000_011_000_00_000_00_00));
        tbl.push_back(mk(OP_LW, 0, 3'd3, 0, 18'b000_011_000_00_000_10_00));
        tbl.push_back(mk(OP_LW, 0, 3'd4, 0, 18'b100_011_000_01_111_10_00));
        // sw
        tbl.push_back(mk(OP_SW, 0, 3'd0, 0, C_IF));
        tbl.push_back(mk(OP_SW, 0, 3'd1, 0, C_0));
        tbl.push_back(mk(OP_SW, 0, 3'd2, 0, 18'b000_011_000_00_000_00_00));
        tbl.push_back(mk(OP_SW, 0, 3'd3, 0, 18'b100_011_000_00_000_01_00));
        // beq taken / not taken, bne taken / not taken
        tbl.push_back(mk(OP_BEQ, 1, 3'd0, 0, C_IF));
        tbl.push_back(mk(OP_BEQ, 1, 3'd1, 0, C_0));
        tbl.push_back(mk(OP_BEQ, 1, 3'd5, 0, 18'b100_001_001_00_000_00_01));
        tbl.push_back(mk(OP_BEQ, 0, 3'd0, 0, C_IF));
        tbl.push_back(mk(OP_BEQ, 0, 3'd1, 0, C_0));
        tbl.push_back(mk(OP_BEQ, 0, 3'd5, 0, 18'b100_001_001_00_000_00_00));
        tbl.push_back(mk(OP_BNE, 0, 3'd0, 0, C_IF));
        tbl.push_back(mk(OP_BNE, 0, 3'd1, 0, C_0));
        tbl.push_back(mk(OP_BNE, 0, 3'd5, 0, 18'b100_001_001_00_000_00_01));
        tbl.push_back(mk(OP_BNE, 1, 3'd0, 0, C_IF));
        tbl.push_back(mk(OP_BNE, 1, 3'd1, 0, C_0));
        tbl.push_back(mk(OP_BNE, 1, 3'd5, 0, 18'b100_001_001_00_000_00_00));
        // sll, ori, andi, addiu, slt
        tbl.push_back(mk(OP_SLL, 0, 3'd0, 0, C_IF));
        tbl.push_back(mk(OP_SLL, 0, 3'd1, 0, C_0));
        tbl.push_back(mk(OP_SLL, 0, 3'd6, 0, 18'b000_100_010_00_000_00_00));
        tbl.push_back(mk(OP_SLL, 0, 3'd7, 0, 18'b100_100_010_10_110_00_00));
        tbl.push_back(mk(OP_ORI, 0, 3'd0, 0, C_IF));
        tbl.push_back(mk(OP_ORI, 0, 3'd1, 0, C_0));
        tbl.push_back(mk(OP_ORI, 0, 3'd6, 0, 18'b000_010_011_00_000_00_00));
        tbl.push_back(mk(OP_ORI, 0, 3'd7, 0, 18'b100_010_011_01_110_00_00));
        tbl.push_back(mk(OP_ANDI, 0, 3'd0, 0, C_IF));
        tbl.push_back(mk(OP_ANDI, 0, 3'd1, 0, C_0));
        tbl.push_back(mk(OP_ANDI, 0, 3'd6, 0, 18'b000_010_100_00_000_00_00));
        tbl.push_back(mk(OP_ANDI, 0, 3'd7, 0, 18'b100_010_100_01_110_00_00));
        tbl.push_back(mk(OP_ADDIU, 0, 3'd0, 0, C_IF));
        tbl.push_back(mk(OP_ADDIU, 0, 3'd1, 0, C_0));
        tbl.push_back(mk(OP_ADDIU, 0, 3'd6, 0, 18'b000_011_000_00_000_00_00));
        tbl.push_back(mk(OP_ADDIU, 0, 3'd7, 0, 18'b100_011_000_01_110_00_00));
        tbl.push_back(mk(OP_SLT, 0, 3'd0, 0, C_IF));
        tbl.push_back(mk(OP_SLT, 0, 3'd1, 0, C_0));
        tbl.push_back(mk(OP_SLT, 0, 3'd6, 0, 18'b000_000_110_00_000_00_00));
        tbl.push_back(mk(OP_SLT, 0, 3'd7, 0, 18'b100_000_110_10_110_00_00));
        // jal, j, jr, undefined NOP
        tbl.push_back(mk(OP_JAL, 0, 3'd0, 0, C_IF));
        tbl.push_back(mk(OP_JAL, 0, 3'd1, 0, 18'b100_000_000_00_100_00_11));
        tbl.push_back(mk(OP_J, 0, 3'd0, 0, C_IF));
        tbl.push_back(mk(OP_J, 0, 3'd1, 0, 18'b100_000_000_00_000_00_11));
        tbl.push_back(mk(OP_JR, 0, 3'd0, 0, C_IF));
        tbl.push_back(mk(OP_JR, 0, 3'd1, 0, 18'b100_000_000_00_000_00_10));
        tbl.push_back(mk(OP_NOP, 0, 3'd0, 0, C_IF));
        tbl.push_back(mk(OP_NOP, 0, 3'd1, 0, 18'b100_000_000_00_000_00_00));
        // halt: IF, ID, then HLT
        tbl.push_back(mk(OP_HALT, 0, 3'd0, 0, C_IF));
        tbl.push_back(mk(OP_HALT, 0, 3'd1, 0, C_0));

        // reset held for 3 cycles
        repeat (3) @(posedge CLK);
        #1;
        check("rst state",  64'(tb_if.state),     64'd0);
        check("rst halted", 64'(tb_if.halted),    64'd0);
        check("rst ctl",    64'(ctl_now()),       64'(C_IF));
        check("rst cycle",  64'(tb_if.cycle_cnt), 64'd0);
        check("rst instr",  64'(tb_if.instr_cnt), 64'd0);
        @(negedge CLK);
        Reset = 1'b1;

        foreach (tbl[i]) apply_row(tbl[i], $sformatf("row%0d", i));

        // HLT: absorbing, no PC write, counters frozen
        hv = mk(OP_HALT, 0, 3'd1, 1, C_0);
        for (int k = 0; k < 10; k++) apply_row(hv, $sformatf("hlt%0d", k));
        check("hlt cycle total", 64'(tb_if.cycle_cnt), 64'(tbl.size()));

        // async reset leaves HLT without a clock edge
        Reset = 1'b0;
        #1;
        check("hlt rst halted", 64'(tb_if.halted), 64'd0);
        check("hlt rst state",  64'(tb_if.state),  64'd0);
        @(negedge CLK);
        Reset = 1'b1;
        exp_cycle = 0;
        exp_instr = 0;

        // sw interrupted by reset during MEM
        apply_row(mk(OP_SW, 0, 3'd0, 0, C_IF), "swr if");
        apply_row(mk(OP_SW, 0, 3'd1, 0, C_0), "swr id");
        apply_row(mk(OP_SW, 0, 3'd2, 0, 18'b000_011_000_00_000_00_00), "swr exe");
        #1;
        check("swr mem mWR",   64'(tb_if.mWR),       64'd1);
        check("swr mem cycle", 64'(tb_if.cycle_cnt), 64'd3);
        #2;
        Reset = 1'b0;
        #1;
        check("swr rst mWR",    64'(tb_if.mWR),       64'd0);
        check("swr rst state",  64'(tb_if.state),     64'd0);
        check("swr rst cycle",  64'(tb_if.cycle_cnt), 64'd0);
        check("swr rst instr",  64'(tb_if.instr_cnt), 64'd0);
        check("swr rst ctl",    64'(ctl_now()),       64'(C_IF));

        // 4-bit counter wrap on the small instance (NOP stream)
        @(negedge CLK);
        Reset = 1'b1;
        tb_if.opcode = OP_NOP;
        repeat (15) @(posedge CLK);
        #1;
        check("wrap cycle 15", 64'(sm_if.cycle_cnt), 64'd15);
        check("wrap instr 7",  64'(sm_if.instr_cnt), 64'd7);
        @(posedge CLK);
        #1;
        check("wrap cycle 0",  64'(sm_if.cycle_cnt), 64'd0);
        check("wrap instr 8",  64'(sm_if.instr_cnt), 64'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
